// File: rtl/alarm_beeper.sv
// Timed buzzer/LED beep sequencer: start pulse launches a finite or
// continuous on/off pattern, stop pulse cancels it at once.
module alarm_beeper #(
   parameter int ON_CYCLES  = 50_000_000,
   parameter int OFF_CYCLES = 50_000_000,
   parameter int BEEPS      = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic trigger,
   input  logic stop,
   input  logic cont,
   output logic buzz,
   output logic busy,
   output logic done
);

   localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int BW   = $clog2(BEEPS + 1);

   localparam logic [PW-1:0] ON_LAST  = PW'(ON_CYCLES - 1);
   localparam logic [PW-1:0] OFF_LAST = PW'(OFF_CYCLES - 1);
   localparam logic [BW-1:0] BEEP_MAX = BW'(BEEPS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_OFF
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [BW-1:0] beep_q, beep_d;
   logic          cont_q, cont_d;
   logic          buzz_q, buzz_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      beep_d  = beep_q;
      cont_d  = cont_q;
      done_d  = 1'b0;
      if (stop) begin
         state_d = S_IDLE;
         phase_d = '0;
         beep_d  = '0;
         cont_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (trigger) begin
                  state_d = S_ON;
                  phase_d = '0;
                  beep_d  = BW'(1);
                  cont_d  = cont;
               end
            end
            S_ON: begin
               if (phase_q == ON_LAST) begin
                  phase_d = '0;
                  if (!cont_q && beep_q == BEEP_MAX) begin
                     state_d = S_IDLE;
                     beep_d  = '0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_OFF;
                  end
               end else begin
                  phase_d = phase_q + PW'(1);
               end
            end
            S_OFF: begin
               if (phase_q == OFF_LAST) begin
                  state_d = S_ON;
                  phase_d = '0;
                  // Saturate so continuous mode never wraps the count
                  if (beep_q != BEEP_MAX) beep_d = beep_q + BW'(1);
               end else begin
                  phase_d = phase_q + PW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               phase_d = '0;
               beep_d  = '0;
            end
         endcase
      end
      buzz_d = (state_d == S_ON);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         beep_q  <= '0;
         cont_q  <= 1'b0;
         buzz_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         beep_q  <= beep_d;
         cont_q  <= cont_d;
         buzz_q  <= buzz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign buzz = buzz_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_alarm_beeper.sv
// Scoreboard bench for alarm_beeper: expected {buzz,busy,done} per cycle
// are queued as stimulus is applied and popped after each edge.
module tb_alarm_beeper;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic trigger = 1'b0;
   logic stop = 1'b0;
   logic cont = 1'b0;
   logic buzz, busy, done;

   logic trig1 = 1'b0;
   logic buzz1, busy1, done1;

   int vectors = 0;
   int errs = 0;
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   alarm_beeper #(.ON_CYCLES(3), .OFF_CYCLES(2), .BEEPS(2)) dut (
      .clk(clk), .rst(rst), .trigger(trigger), .stop(stop),
      .cont(cont), .buzz(buzz), .busy(busy), .done(done)
   );

   alarm_beeper #(.ON_CYCLES(1), .OFF_CYCLES(1), .BEEPS(1)) dut_min (
      .clk(clk), .rst(rst), .trigger(trig1), .stop(1'b0),
      .cont(1'b0), .buzz(buzz1), .busy(busy1), .done(done1)
   );

   // 'B' beeping, 'o' busy and silent, 'D' done pulse, '.' idle
   function automatic logic [2:0] dec(input byte c);
      case (c)
         "B":     return 3'b110;
         "o":     return 3'b010;
         "D":     return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic tick(input logic t, input logic s, input logic c,
                       input logic t1);
      trigger = t;
      stop    = s;
      cont    = c;
      trig1   = t1;
      @(posedge clk);
      #1;
      trigger = 1'b0;
      stop    = 1'b0;
      cont    = 1'b0;
      trig1   = 1'b0;
   endtask

   task automatic test_reset();
      logic [2:0] got, e;
      exp_q.push_back(3'b000);
      exp_q.push_back(3'b000);
      #7;
      got = {buzz, busy, done};
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
         $display("FAIL reset_state got=%b want=%b", got, e);
         errs++;
      end
      got = {buzz1, busy1, done1};
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
         $display("FAIL reset_state_min got=%b want=%b", got, e);
         errs++;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         tick(k == 1, 1'b0, 1'b0, 1'b0);
         exp_q.push_back(dec("B"));
         got = {buzz, busy, done};
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            $display("FAIL reset_preon k=%0d got=%b want=%b", k, got, e);
            errs++;
         end
      end
      #2;
      rst = 1'b1;
      #1;
      exp_q.push_back(3'b000);
      got = {buzz, busy, done};
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
         $display("FAIL reset_async got=%b want=%b", got, e);
         errs++;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         exp_q.push_back(3'b000);
         got = {buzz, busy, done};
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            $display("FAIL reset_idle k=%0d got=%b want=%b", k, got, e);
            errs++;
         end
      end
   endtask

   task automatic test_finite();
      string pat = "BBBooBBBD..";
      logic [2:0] got, e;
      for (int k = 1; k <= pat.len(); k++) begin
         tick(k == 1, 1'b0, 1'b0, 1'b0);
         exp_q.push_back(dec(pat[k-1]));
         got = {buzz, busy, done};
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            $display("FAIL finite k=%0d got=%b want=%b", k, got, e);
            errs++;
         end
      end
   endtask

   task automatic test_stop();
      string pat = "BBBoo........";
      logic [2:0] got, e;
      for (int k = 1; k <= pat.len(); k++) begin
         tick(k == 1, k == 6, 1'b0, 1'b0);
         exp_q.push_back(dec(pat[k-1]));
         got = {buzz, busy, done};
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            $display("FAIL stop k=%0d got=%b want=%b", k, got, e);
            errs++;
         end
      end
   endtask

   task automatic test_cont();
      logic [2:0] got, e;
      for (int k = 1; k <= 103; k++) begin
         tick(k == 1, k == 101, k == 1, 1'b0);
         if (k <= 100)
            exp_q.push_back(((k - 1) % 5 < 3) ? dec("B") : dec("o"));
         else
            exp_q.push_back(dec("."));
         got = {buzz, busy, done};
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            $display("FAIL cont k=%0d got=%b want=%b", k, got, e);
            errs++;
         end
      end
   endtask

   task automatic test_collide();
      string pat = "BBBooBBBD..";
      logic [2:0] got, e;
      for (int k = 1; k <= 3; k++) begin
         tick(k == 1, k == 1, 1'b0, 1'b0);
         exp_q.push_back(dec("."));
         got = {buzz, busy, done};
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            $display("FAIL trig_stop k=%0d got=%b want=%b", k, got, e);
            errs++;
         end
      end
      // Extra triggers (with cont=1) during ON and OFF must not perturb
      for (int k = 1; k <= pat.len(); k++) begin
         tick(k == 1 || k == 3 || k == 5, 1'b0, k != 1, 1'b0);
         exp_q.push_back(dec(pat[k-1]));
         got = {buzz, busy, done};
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            $display("FAIL trig_busy k=%0d got=%b want=%b", k, got, e);
            errs++;
         end
      end
   endtask

   task automatic test_back_to_back();
      string pat = "BBBooBBBDBBBooBBBD..";
      logic [2:0] got, e;
      for (int k = 1; k <= pat.len(); k++) begin
         tick(k == 1 || k == 10, 1'b0, 1'b0, 1'b0);
         exp_q.push_back(dec(pat[k-1]));
         got = {buzz, busy, done};
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            $display("FAIL back_to_back k=%0d got=%b want=%b", k, got, e);
            errs++;
         end
      end
   endtask

   task automatic test_min();
      string pat = "BDBD..";
      logic [2:0] got, e;
      for (int k = 1; k <= pat.len(); k++) begin
         tick(1'b0, 1'b0, 1'b0, k == 1 || k == 3);
         exp_q.push_back(dec(pat[k-1]));
         got = {buzz1, busy1, done1};
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            $display("FAIL min k=%0d got=%b want=%b", k, got, e);
            errs++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_finite();
      test_stop();
      test_cont();
      test_collide();
      test_back_to_back();
      test_min();
      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
         errs++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
